cond_unit_mt: RTL and testbench
===============================

// Module: cond_unit_mt
// PURPOSE
//  Multi-context conditional-execution unit for the pipelined ARMv4 core. Sits at the EX/MEM boundary.
//  Keeps THREADS banks of NZCV flags and evaluates the instruction cond field against the bank picked by ex_tid.
//  Flag writes are gated per NZ/CV group by the decoder's flag_w and by CondEx.
//  Registers the gated write strobes into the MEM stage, with flush/stall bubbles and saturating executed/skipped counters.
// PARAMETERS
//  THREADS  2   number of flag banks (hardware contexts), >=1; TID_W = max(1,$clog2(THREADS))
//  CNT_W    16  width of exec_cnt / skip_cnt
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-low
//  ex_valid   in   1      EX-stage instruction valid
//  ex_tid     in   TID_W  context id of EX instruction
//  cond       in   4      instruction condition field [31:28]
//  alu_flags  in   4      {N,Z,C,V} produced by ALU this cycle
//  flag_w     in   2      [1]=write NZ, [0]=write CV (from decoder)
//  pcs        in   1      decoder PC-write request
//  reg_w      in   1      decoder register-write request
//  mem_w      in   1      decoder memory-write request
//  no_write   in   1      CMP/CMN/TST/TEQ: suppress register write
//  stall      in   1      hold EX; inject bubble into MEM
//  flush      in   1      kill EX instruction (branch taken / exception)
//  clr_cnt    in   1      synchronous counter clear
//  flags_o    out  4      current flags of bank[ex_tid] (combinational)
//  m_valid    out  1      MEM-stage instruction valid (registered)
//  m_tid      out  TID_W  MEM-stage context id
//  pcsrc      out  1      registered pcs & CondEx
//  reg_write  out  1      registered reg_w & CondEx & ~no_write
//  mem_write  out  1      registered mem_w & CondEx
//  cond_ex    out  1      registered CondEx
//  undef_cond out  1      registered: cond==4'b1111 or ex_tid>=THREADS
//  exec_cnt   out  CNT_W  instructions that fired with CondEx=1
//  skip_cnt   out  CNT_W  instructions that fired with CondEx=0
// BEHAVIOUR
//  - Reset (rst=0, async): every flag bank, every M-stage output and both counters = 0.
//  - fire = ex_valid & ~stall & ~flush. flush has priority over stall.
//  - CondEx is combinational from bank[ex_tid] register contents:
//    0000 EQ Z, 0001 NE ~Z, 0010 CS C, 0011 CC ~C, 0100 MI N, 0101 PL ~N, 0110 VS V, 0111 VC ~V,
//    1000 HI C&~Z, 1001 LS ~(C&~Z), 1010 GE N==V, 1011 LT N!=V, 1100 GT ~Z&(N==V),
//    1101 LE ~(~Z&(N==V)), 1110 AL 1, 1111 -> CondEx=0 and undef=1.
//  - An ex_tid >= THREADS forces CondEx=0 and undef=1, with no flag update.
//  - Flag update at the clock edge when fire & CondEx:
//    flag_w[1] -> bank[ex_tid][3:2] <= alu_flags[3:2]; flag_w[0] -> bank[ex_tid][1:0] <= alu_flags[1:0].
//    Other banks are untouched.
//  - Back-to-back on the same tid: the instruction at N+1 sees the flags written at N. No bypass is needed; latency is 1 edge.
//  - M register: on fire it loads m_valid=1, m_tid, the gated strobes, cond_ex and undef_cond.
//    Otherwise (stall, flush or ~ex_valid) it loads a bubble: all M outputs = 0.
//  - Counters: clr_cnt has priority and clears both to 0. Else fire&CondEx -> exec_cnt+1; fire&~CondEx -> skip_cnt+1.
//    Both saturate at all-ones; no wrap.
//  - A flushed or stalled instruction changes no flags and no counters.
//  - Reset asserted mid-stream clears state immediately, independent of clk.
// TESTING
//  1 Reset: rst=0 with random inputs -> all outputs 0, flags_o=0; release, cond=1110 AL, reg_w=1, fire -> next cycle reg_write=1, m_valid=1, exec_cnt=1.
//  2 Partial flag write: tid0 alu_flags=1111, flag_w=10, AL -> bank0=1100; then cond=0000 EQ -> cond_ex=1; cond=0010 CS -> cond_ex=0.
//  3 Bank isolation (THREADS=2): tid1 writes Z=1; tid0 EQ -> cond_ex=0, skip_cnt+1; tid1 EQ -> cond_ex=1.
//  4 Gating: Z=0, cond=0000, reg_w=mem_w=pcs=1, flag_w=11 -> all strobes 0, flags unchanged; CMP AL with no_write=1 -> reg_write=0, flags written.
//  5 Flush/stall: flush=stall=1 with an AL flag write -> bubble, flags and counters unchanged; stall only -> bubble, EX held, then fires once.
//  6 Edges: cond=1111 -> undef_cond=1, cond_ex=0; CNT_W=2 with 5 AL fires -> exec_cnt=3; clr_cnt concurrent with fire -> 0.

Source files
------------

// File: rtl/cond_unit_mt.sv
// ---------------------------------------------------------------------------
// cond_unit_mt
// Multi-context conditional-execution unit for the pipelined ARMv4 core,
// placed at the EX/MEM boundary. It holds one NZCV flag bank per hardware
// context. It evaluates the instruction condition field against the bank
// selected by ex_tid. It gates flag writes and the decoder write strobes with
// the condition result, and registers the gated strobes into the MEM stage.
// It also keeps saturating counts of executed and skipped instructions.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   ex_valid        EX-stage instruction valid
//   ex_tid          context id of the EX instruction
//   cond            instruction condition field [31:28]
//   alu_flags       {N,Z,C,V} from the ALU this cycle
//   flag_w          [1] write NZ, [0] write CV
//   pcs/reg_w/mem_w decoder PC / register / memory write requests
//   no_write        compare/test ops: suppress the register write
//   stall, flush    hold EX / kill EX; both put a bubble into MEM
//   clr_cnt         synchronous clear of both counters
//   flags_o         flags of bank[ex_tid] (combinational, 0 for bad tid)
//   m_valid, m_tid  MEM-stage valid and context id
//   pcsrc, reg_write, mem_write, cond_ex, undef_cond  registered MEM results
//   exec_cnt, skip_cnt  saturating executed / skipped instruction counters
// ---------------------------------------------------------------------------
module cond_unit_mt #(
    parameter int THREADS = 2,
    parameter int CNT_W   = 16,
    localparam int TID_W  = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [TID_W-1:0] ex_tid,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    input  logic             stall,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic [3:0]       flags_o,
    output logic             m_valid,
    output logic [TID_W-1:0] m_tid,
    output logic             pcsrc,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic             undef_cond,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    // The bank array covers every encodable tid so indexing never goes out of
    // range; banks at or above THREADS are never written.
    localparam int NBANK = 1 << TID_W;

    logic [3:0] bank [NBANK];
    logic [3:0] cur;
    logic       tid_bad;
    logic       cond_true;
    logic       ce;
    logic       undef;
    logic       fire;
    logic       n, z, c, v;

    assign tid_bad = ({1'b0, ex_tid} >= (TID_W+1)'(THREADS));
    assign cur     = bank[ex_tid];
    assign flags_o = tid_bad ? 4'b0000 : cur;
    assign {n, z, c, v} = cur;

    // flush outranks stall, but either one alone already blocks the fire.
    assign fire  = ex_valid & ~stall & ~flush;
    assign undef = (cond == 4'b1111) | tid_bad;
    assign ce    = cond_true & ~tid_bad;

    // Condition decode; 1111 is the undefined encoding and never executes.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'b0000: cond_true = z;
            4'b0001: cond_true = ~z;
            4'b0010: cond_true = c;
            4'b0011: cond_true = ~c;
            4'b0100: cond_true = n;
            4'b0101: cond_true = ~n;
            4'b0110: cond_true = v;
            4'b0111: cond_true = ~v;
            4'b1000: cond_true = c & ~z;
            4'b1001: cond_true = ~(c & ~z);
            4'b1010: cond_true = (n == v);
            4'b1011: cond_true = (n != v);
            4'b1100: cond_true = ~z & (n == v);
            4'b1101: cond_true = ~(~z & (n == v));
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Flag banks: only the selected bank, and only the enabled NZ/CV groups,
    // change when an instruction fires and passes its condition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NBANK; i++) begin
                bank[i] <= 4'b0000;
            end
        end else if (fire && ce) begin
            if (flag_w[1]) bank[ex_tid][3:2] <= alu_flags[3:2];
            if (flag_w[0]) bank[ex_tid][1:0] <= alu_flags[1:0];
        end
    end

    // MEM-stage register: a fired instruction loads its gated strobes,
    // anything else loads an all-zero bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid    <= 1'b0;
            m_tid      <= '0;
            pcsrc      <= 1'b0;
            reg_write  <= 1'b0;
            mem_write  <= 1'b0;
            cond_ex    <= 1'b0;
            undef_cond <= 1'b0;
        end else if (fire) begin
            m_valid    <= 1'b1;
            m_tid      <= ex_tid;
            pcsrc      <= pcs & ce;
            reg_write  <= reg_w & ce & ~no_write;
            mem_write  <= mem_w & ce;
            cond_ex    <= ce;
            undef_cond <= undef;
        end else begin
            m_valid    <= 1'b0;
            m_tid      <= '0;
            pcsrc      <= 1'b0;
            reg_write  <= 1'b0;
            mem_write  <= 1'b0;
            cond_ex    <= 1'b0;
            undef_cond <= 1'b0;
        end
    end

    // Saturating counters; a clear wins over a concurrent increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else if (clr_cnt) begin
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else if (fire) begin
            if (ce) begin
                if (exec_cnt != '1) exec_cnt <= exec_cnt + CNT_W'(1);
            end else begin
                if (skip_cnt != '1) skip_cnt <= skip_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cond_unit_mt.sv
// ---------------------------------------------------------------------------
// tb_cond_unit_mt
// Drives two cond_unit_mt instances with the same stimulus: one with 16-bit
// counters and one with 2-bit counters so that saturation is reachable.
// A reference model tracks flag banks, MEM-stage results and counters.
// ---------------------------------------------------------------------------
module tb_cond_unit_mt;

    localparam int THREADS = 2;
    localparam int CNT_W   = 16;
    localparam int CNT_WS  = 2;
    localparam logic [31:0] MAX_L = (32'd1 << CNT_W) - 1;
    localparam logic [31:0] MAX_S = (32'd1 << CNT_WS) - 1;

    logic clk = 1'b0;
    logic rst;
    logic ex_valid, ex_tid, pcs, reg_w, mem_w, no_write, stall, flush, clr_cnt;
    logic [3:0] cond, alu_flags;
    logic [1:0] flag_w;

    logic [3:0] flags_o, flags_o_s;
    logic m_valid, m_tid, pcsrc, reg_write, mem_write, cond_ex, undef_cond;
    logic m_valid_s, m_tid_s, pcsrc_s, reg_write_s, mem_write_s, cond_ex_s, undef_cond_s;
    logic [CNT_W-1:0]  exec_cnt, skip_cnt;
    logic [CNT_WS-1:0] exec_cnt_s, skip_cnt_s;

    int testCount = 0;
    int failCount = 0;

    // Reference model state.
    logic [3:0]  mBank [THREADS];
    logic [31:0] mExec, mSkip, mExecS, mSkipS;
    logic        eValid, eTid, ePcsrc, eRegW, eMemW, eCe, eUndef;

    always #5 clk = ~clk;

    cond_unit_mt #(.THREADS(THREADS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_tid(ex_tid), .cond(cond),
        .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w),
        .mem_w(mem_w), .no_write(no_write), .stall(stall), .flush(flush),
        .clr_cnt(clr_cnt), .flags_o(flags_o), .m_valid(m_valid), .m_tid(m_tid),
        .pcsrc(pcsrc), .reg_write(reg_write), .mem_write(mem_write),
        .cond_ex(cond_ex), .undef_cond(undef_cond), .exec_cnt(exec_cnt),
        .skip_cnt(skip_cnt)
    );

    cond_unit_mt #(.THREADS(THREADS), .CNT_W(CNT_WS)) dut_s (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_tid(ex_tid), .cond(cond),
        .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w),
        .mem_w(mem_w), .no_write(no_write), .stall(stall), .flush(flush),
        .clr_cnt(clr_cnt), .flags_o(flags_o_s), .m_valid(m_valid_s), .m_tid(m_tid_s),
        .pcsrc(pcsrc_s), .reg_write(reg_write_s), .mem_write(mem_write_s),
        .cond_ex(cond_ex_s), .undef_cond(undef_cond_s), .exec_cnt(exec_cnt_s),
        .skip_cnt(skip_cnt_s)
    );

    // ARM condition semantics written from the mnemonic meanings.
    function automatic logic evalCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < THREADS; i++) mBank[i] = 4'b0000;
        mExec = 0; mSkip = 0; mExecS = 0; mSkipS = 0;
        {eValid, eTid, ePcsrc, eRegW, eMemW, eCe, eUndef} = 7'b0;
    endtask

    // Compares every registered output of both instances with the model.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".flags"},     flags_o,     mBank[ex_tid]);
        checkOutput({tag, ".flags_s"},   flags_o_s,   mBank[ex_tid]);
        checkOutput({tag, ".m_valid"},   m_valid,     eValid);
        checkOutput({tag, ".m_tid"},     m_tid,       eTid);
        checkOutput({tag, ".pcsrc"},     pcsrc,       ePcsrc);
        checkOutput({tag, ".reg_write"}, reg_write,   eRegW);
        checkOutput({tag, ".mem_write"}, mem_write,   eMemW);
        checkOutput({tag, ".cond_ex"},   cond_ex,     eCe);
        checkOutput({tag, ".undef"},     undef_cond,  eUndef);
        checkOutput({tag, ".exec"},      exec_cnt,    mExec);
        checkOutput({tag, ".skip"},      skip_cnt,    mSkip);
        checkOutput({tag, ".m_valid_s"}, m_valid_s,   eValid);
        checkOutput({tag, ".cond_ex_s"}, cond_ex_s,   eCe);
        checkOutput({tag, ".reg_w_s"},   reg_write_s, eRegW);
        checkOutput({tag, ".exec_s"},    exec_cnt_s,  mExecS);
        checkOutput({tag, ".skip_s"},    skip_cnt_s,  mSkipS);
    endtask

    // Drives one cycle, checks the combinational flags before the edge,
    // advances the model across the edge and checks everything after it.
    task automatic applyStimulus(input string tag, input logic v, input logic t,
                                 input logic [3:0] c, input logic [3:0] af,
                                 input logic [1:0] fw, input logic p, input logic rw,
                                 input logic mw, input logic nw, input logic st,
                                 input logic fl, input logic clr);
        logic fire, ce;
        ex_valid = v; ex_tid = t; cond = c; alu_flags = af; flag_w = fw;
        pcs = p; reg_w = rw; mem_w = mw; no_write = nw; stall = st; flush = fl;
        clr_cnt = clr;
        #1;
        checkOutput({tag, ".pre_flags"}, flags_o, mBank[t]);
        fire = v && !st && !fl;
        ce   = evalCond(c, mBank[t]);
        @(posedge clk);
        #1;
        if (fire) begin
            eValid = 1'b1; eTid = t; ePcsrc = p && ce; eRegW = rw && ce && !nw;
            eMemW = mw && ce; eCe = ce; eUndef = (c == 4'hF);
        end else begin
            {eValid, eTid, ePcsrc, eRegW, eMemW, eCe, eUndef} = 7'b0;
        end
        if (fire && ce) begin
            if (fw[1]) mBank[t][3:2] = af[3:2];
            if (fw[0]) mBank[t][1:0] = af[1:0];
        end
        if (clr) begin
            mExec = 0; mSkip = 0; mExecS = 0; mSkipS = 0;
        end else if (fire && ce) begin
            if (mExec < MAX_L) mExec++;
            if (mExecS < MAX_S) mExecS++;
        end else if (fire) begin
            if (mSkip < MAX_L) mSkip++;
            if (mSkipS < MAX_S) mSkipS++;
        end
        checkAll(tag);
    endtask

    task automatic randomInputs();
        ex_valid = 1'($urandom); ex_tid = 1'($urandom); cond = 4'($urandom);
        alu_flags = 4'($urandom); flag_w = 2'($urandom); pcs = 1'($urandom);
        reg_w = 1'($urandom); mem_w = 1'($urandom); no_write = 1'($urandom);
        stall = 1'($urandom); flush = 1'($urandom); clr_cnt = 1'($urandom);
    endtask

    initial begin
        // Test 1: reset with random inputs, then one AL register write.
        rst = 1'b0;
        randomInputs();
        ex_tid = 1'b0;
        modelReset();
        #3;
        checkAll("t1_reset");
        @(posedge clk);
        #1;
        checkAll("t1_reset_clk");
        rst = 1'b1;
        applyStimulus("t1_al", 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("t1_reg_write", reg_write, 1);
        checkOutput("t1_m_valid", m_valid, 1);
        checkOutput("t1_exec_cnt", exec_cnt, 1);

        // Test 2: NZ-only write on bank 0, then EQ passes and CS fails.
        applyStimulus("t2_wr", 1, 0, 4'hE, 4'hF, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_bank0", flags_o, 4'b1100);
        applyStimulus("t2_eq", 1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_eq_ce", cond_ex, 1);
        applyStimulus("t2_cs", 1, 0, 4'h2, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_cs_ce", cond_ex, 0);

        // Test 3: bank isolation between contexts.
        applyStimulus("t3_clr0", 1, 0, 4'hE, 4'h0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("t3_wr1", 1, 1, 4'hE, 4'b0100, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("t3_eq0", 1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_eq0_ce", cond_ex, 0);
        checkOutput("t3_skip", skip_cnt, 2);
        applyStimulus("t3_eq1", 1, 1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_eq1_ce", cond_ex, 1);

        // Test 4: failed condition gates all strobes; compare suppresses reg write.
        applyStimulus("t4_gate", 1, 0, 4'h0, 4'hF, 2'b11, 1, 1, 1, 0, 0, 0, 0);
        checkOutput("t4_reg_write", reg_write, 0);
        checkOutput("t4_mem_write", mem_write, 0);
        checkOutput("t4_pcsrc", pcsrc, 0);
        checkOutput("t4_flags", flags_o, 4'b0000);
        applyStimulus("t4_cmp", 1, 0, 4'hE, 4'b0110, 2'b11, 0, 1, 0, 1, 0, 0, 0);
        checkOutput("t4_cmp_regw", reg_write, 0);
        checkOutput("t4_cmp_flags", flags_o, 4'b0110);

        // Test 5: flush+stall and stall-only bubbles, then the held op fires.
        applyStimulus("t5_fs", 1, 0, 4'hE, 4'b1001, 2'b11, 0, 1, 0, 0, 1, 1, 0);
        checkOutput("t5_fs_valid", m_valid, 0);
        checkOutput("t5_fs_flags", flags_o, 4'b0110);
        applyStimulus("t5_st", 1, 0, 4'hE, 4'b1001, 2'b11, 0, 1, 0, 0, 1, 0, 0);
        checkOutput("t5_st_valid", m_valid, 0);
        applyStimulus("t5_go", 1, 0, 4'hE, 4'b1001, 2'b11, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("t5_go_valid", m_valid, 1);
        checkOutput("t5_exec", exec_cnt, 8);
        checkOutput("t5_skip", skip_cnt, 3);

        // Test 6: undefined condition, saturation, clear beats fire.
        applyStimulus("t6_nv", 1, 0, 4'hF, 4'h0, 2'b11, 1, 1, 1, 0, 0, 0, 0);
        checkOutput("t6_undef", undef_cond, 1);
        checkOutput("t6_nv_ce", cond_ex, 0);
        applyStimulus("t6_clr", 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            applyStimulus("t6_al", 1, 1'(i), 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("t6_sat_s", exec_cnt_s, 3);
        checkOutput("t6_exec_l", exec_cnt, 5);
        applyStimulus("t6_clrfire", 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 1);
        checkOutput("t6_clr_exec", exec_cnt, 0);
        checkOutput("t6_clr_exec_s", exec_cnt_s, 0);

        // Randomized traffic with a reset dropped in mid-stream.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                randomInputs();
                rst = 1'b0;
                modelReset();
                #2;
                checkAll("rnd_async_rst");
                #10;
                rst = 1'b1;
            end
            applyStimulus("rnd",
                ($urandom_range(0, 7) != 0), 1'($urandom), 4'($urandom),
                4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
